// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_pkg
// Purpose  : Shared PHY link constants: COM symbol, FSM state encodings and
//            default alignment count. Used by both transmitter and receiver.
// Revision : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam logic [7:0] COM_SYMBOL       = 8'hBC;
    localparam int         BC_COUNT_DEFAULT = 4;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serie_paralelo.sv
`default_nettype none
// ============================================================================
// Module   : serie_paralelo
// Purpose  : Serial-to-parallel PHY receiver; aligns on COM (0xBC) and
//            delivers non-COM bytes. Optional macro: SP_LOCK_LOSS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serie_paralelo
    import phy_pkg::*;
#(
    parameter int BC_COUNT = BC_COUNT_DEFAULT
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] c_bc_target = 4'(BC_COUNT);

    // Only the newest seven bits are needed; the window appends the live bit.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [1:0] r_state;
    logic [3:0] r_bc_cnt;

    logic [7:0] w_window;
    logic       w_is_com;
    logic       w_boundary;

    assign w_window   = {r_sr, data_in};
    assign w_is_com   = (w_window == COM_SYMBOL);
    assign w_boundary = (r_bit_cnt == 3'd7);

`ifdef SP_LOCK_LOSS_EN
    logic [2:0] r_offset;
    logic       r_pending;
    logic       w_same_offset;

    assign w_same_offset = r_pending && (r_offset == r_bit_cnt);
`endif

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_sr      <= 7'h00;
            r_bit_cnt <= 3'd0;
            r_state   <= ST_HUNT;
            r_bc_cnt  <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
`ifdef SP_LOCK_LOSS_EN
            r_offset  <= 3'd0;
            r_pending <= 1'b0;
`endif
        end else begin
            r_sr      <= w_window[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            case (r_state)
                ST_HUNT: begin
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_bc_cnt  <= 4'd1;
                        if (c_bc_target <= 4'd1) begin
                            r_state <= ST_ACTIVE;
                            active  <= 1'b1;
                        end else begin
                            r_state <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (w_boundary) begin
                        if (w_is_com) begin
                            r_bc_cnt <= r_bc_cnt + 4'd1;
                            if ((r_bc_cnt + 4'd1) >= c_bc_target) begin
                                r_state <= ST_ACTIVE;
                                active  <= 1'b1;
                            end
                        end else begin
                            r_state  <= ST_HUNT;
                            r_bc_cnt <= 4'd0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_boundary) begin
                        if (!w_is_com) begin
                            data_out  <= w_window;
                            valid_out <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end
`ifdef SP_LOCK_LOSS_EN
                    // A COM repeating at the same off-boundary phase means the
                    // transmitter has slipped: realign to that phase.
                    else if (w_is_com) begin
                        if (w_same_offset) begin
                            r_state   <= ST_ALIGN;
                            r_bc_cnt  <= 4'd1;
                            r_bit_cnt <= 3'd0;
                            active    <= 1'b0;
                            valid_out <= 1'b0;
                            r_pending <= 1'b0;
                        end else begin
                            r_pending <= 1'b1;
                            r_offset  <= r_bit_cnt;
                        end
                    end else if (w_same_offset) begin
                        r_pending <= 1'b0;
                    end
`endif
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serie_paralelo.sv
`default_nettype none
// ============================================================================
// Module   : tb_serie_paralelo
// Purpose  : Self-checking bench for serie_paralelo against a behavioural
//            stream model; honours SP_LOCK_LOSS_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serie_paralelo;

    localparam int         BCC = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk_8f  = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int errors = 0;
    int checks = 0;

    serie_paralelo #(.BC_COUNT(BCC)) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_8f = ~clk_8f;

    // Behavioural model: mode 0 = hunting, 1 = counting COMs, 2 = delivering.
    logic [7:0] m_hist;
    int         m_mode, m_ncom, m_since, m_cyc, m_last_mis, m_last_phase;
    logic [7:0] m_dout;
    logic       m_vout, m_act;

    task automatic model_reset();
        m_hist = 8'h00; m_mode = 0; m_ncom = 0; m_since = 0;
        m_dout = 8'h00; m_vout = 1'b0; m_act = 1'b0;
        m_last_mis = -1; m_last_phase = 0;
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic [7:0] win;
        int         phase;
        logic       bnd;
        m_cyc++;
        if (r) begin
            model_reset();
            return;
        end
        win    = {m_hist[6:0], b};
        m_hist = win;
        // Edges since the alignment reference; every 8th is a byte boundary.
        phase  = m_since % 8;
        bnd    = (phase == 7);
        m_since++;
        if (m_mode == 0) begin
            if (win == COM) begin
                m_since = 0;
                m_ncom  = 1;
                if (BCC == 1) begin m_mode = 2; m_act = 1'b1; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (bnd) begin
                if (win == COM) begin
                    m_ncom++;
                    if (m_ncom >= BCC) begin m_mode = 2; m_act = 1'b1; end
                end else begin
                    m_mode = 0; m_ncom = 0;
                end
            end
        end else begin
            if (bnd) begin
                if (win != COM) begin m_dout = win; m_vout = 1'b1; end
                else m_vout = 1'b0;
            end
`ifdef SP_LOCK_LOSS_EN
            else if (win == COM) begin
                if (m_last_mis >= 0 && (m_cyc - m_last_mis) == 8 && phase == m_last_phase) begin
                    m_mode = 1; m_ncom = 1; m_since = 0;
                    m_act = 1'b0; m_vout = 1'b0; m_last_mis = -1;
                end else begin
                    m_last_mis = m_cyc; m_last_phase = phase;
                end
            end
`endif
        end
    endtask

    task automatic step(input logic b, input logic r);
        reset   = r;
        data_in = b;
        @(posedge clk_8f);
        model_edge(b, r);
        #1;
        checks++;
        if (data_out !== m_dout || valid_out !== m_vout || active !== m_act) begin
            errors++;
            $display("FAIL cycle%0d: got data_out=%h valid_out=%b active=%b, want %h %b %b",
                     m_cyc, data_out, valid_out, active, m_dout, m_vout, m_act);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) step(v[i], 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        repeat (3) step(1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0);
        chk("idle_active", {7'd0, active}, 8'h00);
        chk("idle_valid", {7'd0, valid_out}, 8'h00);
        chk("idle_data", data_out, 8'h00);

        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        repeat (3) send_byte(COM);
        send_bits(COM, 7);
        chk("pre_lock_active", {7'd0, active}, 8'h00);
        step(1'b0, 1'b0);
        chk("lock_active", {7'd0, active}, 8'h01);
        chk("lock_valid", {7'd0, valid_out}, 8'h00);

        send_byte(8'hFF);
        chk("ff_data", data_out, 8'hFF);
        chk("ff_valid", {7'd0, valid_out}, 8'h01);
        send_bits(8'hEE, 7);
        chk("ff_hold", data_out, 8'hFF);
        step(1'b0, 1'b0);
        chk("ee_data", data_out, 8'hEE);
        send_byte(COM);
        chk("com_valid", {7'd0, valid_out}, 8'h00);
        chk("com_hold", data_out, 8'hEE);
        send_byte(8'h11);
        chk("d11_data", data_out, 8'h11);
        chk("d11_valid", {7'd0, valid_out}, 8'h01);

        send_bits(8'hA5, 4);
        step(1'b0, 1'b1);
        chk("rst_all", {data_out[6:0], valid_out}, 8'h00);
        chk("rst_active", {7'd0, active}, 8'h00);

        repeat (3) send_byte(COM);
        send_byte(8'h11);
        chk("align_abort", {7'd0, active}, 8'h00);
        repeat (3) send_byte(COM);
        chk("relock_pre", {7'd0, active}, 8'h00);
        send_byte(COM);
        chk("relock", {7'd0, active}, 8'h01);

`ifdef SP_LOCK_LOSS_EN
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        send_byte(COM);
        chk("slip_first", {7'd0, active}, 8'h01);
        send_byte(COM);
        chk("slip_drop", {7'd0, active}, 8'h00);
        chk("slip_valid", {7'd0, valid_out}, 8'h00);
        repeat (2) send_byte(COM);
        chk("slip_pre", {7'd0, active}, 8'h00);
        send_byte(COM);
        chk("slip_relock", {7'd0, active}, 8'h01);
`endif

        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(1'($urandom_range(0, 1)), 1'b1);
                repeat (BCC) send_byte(COM);
            end else if (r < 40) begin
                send_byte(COM);
            end else if (r < 46) begin
                repeat ($urandom_range(1, 7)) step(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                send_byte(8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serie_paralelo.md
# serie_paralelo

Serial-to-parallel receiver for the PHY link: the receive end of the parallel-to-serial transmitter. It samples one bit per `clk_8f` cycle and hunts for the COM symbol (0xBC) to find byte alignment. After `BC_COUNT` consecutive aligned COM bytes it asserts `active`, then delivers each non-COM byte on `data_out` with `valid_out`, held for one 8-cycle frame.

## Interface
- `COM_SYMBOL`, 8'hBC, idle/alignment symbol the transmitter sends when its `valid_in` is low.
- `BC_COUNT`, 4, consecutive aligned COM bytes required before `active` rises (legal range 1–15).
- `clk_8f`  input  1  bit clock. Single clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  1  serial data, MSB first.
- `data_out`  output  8  received byte.
- `valid_out`  output  1  `data_out` holds a data (non-COM) byte.
- `active`  output  1  link aligned and delivering.

## Operation
- Shift register `sr[7:0]`: `sr <= {sr[6:0], data_in}` every cycle, in every state. Call the post-shift value "window".
- Bit counter `bit_cnt[2:0]`. A "boundary" is the cycle in which the 8th bit of an aligned byte is sampled, i.e. `bit_cnt==7`. The counter wraps 7→0.
- FSM states: HUNT, ALIGN, ACTIVE.
  - HUNT: every cycle, if window==COM_SYMBOL, go to ALIGN with `bc_cnt=1` and `bit_cnt=0` (this cycle becomes the boundary reference). `bit_cnt` is don't-care while in HUNT.
  - ALIGN: at a boundary, if window==COM_SYMBOL, increment `bc_cnt`; when it reaches `BC_COUNT`, go to ACTIVE and set `active=1` at that edge. At a boundary, if window!=COM_SYMBOL, go to HUNT and set `bc_cnt=0`. If `BC_COUNT==1`, go directly from HUNT to ACTIVE.
  - ACTIVE: at each boundary, if window!=COM_SYMBOL, set `data_out<=window` and `valid_out<=1`. If window==COM_SYMBOL, set `valid_out<=0` and leave `data_out` unchanged. Between boundaries both outputs hold.
- `active` stays at 1 until reset, unless `SP_LOCK_LOSS_EN` is defined.
- `valid_out` is always 0 outside ACTIVE.

## Timing
- Reset values: `data_out=8'h00`, `valid_out=0`, `active=0`, state HUNT, `bc_cnt=0`, `bit_cnt=0`, `sr=8'h00`.
- Reset asserted mid-byte or mid-ALIGN: the next edge applies the reset values. Partial bytes are discarded. Hunting restarts on the first cycle after `reset` deasserts.
- Latency: outputs update on the same edge that samples the byte's last bit, and are held for exactly 8 edges.
- `active` rises on the boundary edge of the `BC_COUNT`-th COM byte. The first data byte can appear at the next boundary, 8 cycles later.
- A COM at the last ALIGN boundary combined with reset: reset wins.

## Configuration
- `SP_LOCK_LOSS_EN` defined:
  - In ACTIVE, a misaligned COM is a window==COM_SYMBOL at a non-boundary cycle.
  - A misaligned COM at the same `bit_cnt` offset in two consecutive frames drops `active` and `valid_out` at the second occurrence's edge.
  - The FSM then enters ALIGN with `bc_cnt=1` and `bit_cnt=0`, realigned to that offset.
  - Requires a 3-bit offset register and a 1-bit pending flag.
- Macro not defined: ACTIVE is terminal until reset, and misaligned COM patterns are ignored.

## Structure
- Shared package `phy_pkg`: COM symbol constant (8'hBC), FSM state encodings (HUNT/ALIGN/ACTIVE), default `BC_COUNT`. The transmitter uses the same COM constant.
- No sub-module. Shift register, counters and FSM stay flat in `serie_paralelo`.

## Test plan
- Reset high 3 cycles, then serial zeros for 40 cycles -> `active=0`, `valid_out=0`, `data_out=8'h00` throughout.
- 3 junk bits, then 4× 0xBC MSB first -> `active` rises on the edge of the 32nd BC bit; `valid_out` stays 0.
- After `active`, send 0xFF then 0xEE -> `data_out=8'hFF`, `valid_out=1` for 8 cycles from the FF boundary, then `8'hEE` for 8 cycles.
- ACTIVE, send 0xEE, 0xBC, 0x11 -> `valid_out` goes 1, then 0 with `data_out` holding 8'hEE, then 1 with 8'h11.
- 3× 0xBC then 0x11 during ALIGN -> back to HUNT with `active=0`; a following 4× 0xBC -> `active=1`.
- Reset pulsed mid-data -> all outputs are 0 on the next edge and the link realigns only after a fresh `BC_COUNT` COMs.
- With `SP_LOCK_LOSS_EN`: shift the stream by 2 bits while sending COMs -> `active` drops on the second misaligned COM, then relocks after 4 total aligned COMs.
